// File: rtl/layer_ctrl_pkg.sv
// Shared definitions for the layer control bank: header field positions,
// register ids and command parser state encoding.
package layer_ctrl_pkg;

  localparam int HDR_LAYER_MSB = 7;
  localparam int HDR_LAYER_LSB = 6;
  localparam int HDR_REG_MSB   = 5;
  localparam int HDR_REG_LSB   = 2;
  localparam int HDR_RSVD_MSB  = 1;
  localparam int HDR_RSVD_LSB  = 0;

  localparam logic [3:0] REG_MODE     = 4'd0;
  localparam logic [3:0] REG_SCALE    = 4'd1;
  localparam logic [3:0] REG_TRANS    = 4'd2;
  localparam logic [3:0] REG_OFFSET_X = 4'd3;
  localparam logic [3:0] REG_OFFSET_Y = 4'd4;
  localparam logic [3:0] REG_CLIP_L   = 4'd5;
  localparam logic [3:0] REG_CLIP_R   = 4'd6;
  localparam logic [3:0] REG_CLIP_T   = 4'd7;
  localparam logic [3:0] REG_CLIP_B   = 4'd8;
  localparam logic [3:0] REG_FREEZE   = 4'd9;
  localparam logic [3:0] REG_COMMIT   = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PAY_HI = 2'd1,
    ST_PAY_LO = 2'd2
  } parse_state_t;

  function automatic logic is_two_byte(input logic [3:0] reg_id);
    return (reg_id >= REG_OFFSET_X) && (reg_id <= REG_CLIP_B);
  endfunction

endpackage

// File: rtl/layer_ctrl_slice.sv
// One foreground layer's shadow/active register set: writes land in the
// shadow copy, a commit copies every shadow field to the active outputs.
module layer_ctrl_slice
  import layer_ctrl_pkg::*;
#(
  parameter int PRECISION              = 11,
  parameter int TRANSPARENCY_PRECISION = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [3:0]                        wr_reg,
  input  logic [15:0]                       wr_data,
  input  logic                              commit,
  output logic [1:0]                        mode,
  output logic [1:0]                        scale,
  output logic [PRECISION:0]                offset_x,
  output logic [PRECISION:0]                offset_y,
  output logic [TRANSPARENCY_PRECISION-1:0] transparency,
  output logic [PRECISION-1:0]              clip_left,
  output logic [PRECISION-1:0]              clip_right,
  output logic [PRECISION-1:0]              clip_top,
  output logic [PRECISION-1:0]              clip_bottom
);

  logic [1:0]                        mode_shadow_reg, scale_shadow_reg;
  logic [PRECISION:0]                offset_x_shadow_reg, offset_y_shadow_reg;
  logic [TRANSPARENCY_PRECISION-1:0] trans_shadow_reg;
  logic [PRECISION-1:0]              clip_l_shadow_reg, clip_r_shadow_reg;
  logic [PRECISION-1:0]              clip_t_shadow_reg, clip_b_shadow_reg;

  // Narrow fields keep only the low payload bits; the rest is discarded.
  logic unused_data;
  assign unused_data = ^wr_data;

  // Non-blocking copy means a commit on the same edge as a write sees the old shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_shadow_reg     <= '0;
      scale_shadow_reg    <= '0;
      offset_x_shadow_reg <= '0;
      offset_y_shadow_reg <= '0;
      trans_shadow_reg    <= '0;
      clip_l_shadow_reg   <= '0;
      clip_r_shadow_reg   <= '0;
      clip_t_shadow_reg   <= '0;
      clip_b_shadow_reg   <= '0;
      mode                <= '0;
      scale               <= '0;
      offset_x            <= '0;
      offset_y            <= '0;
      transparency        <= '0;
      clip_left           <= '0;
      clip_right          <= '0;
      clip_top            <= '0;
      clip_bottom         <= '0;
    end else begin
      if (wr_en) begin
        case (wr_reg)
          REG_MODE:     mode_shadow_reg     <= wr_data[1:0];
          REG_SCALE:    scale_shadow_reg    <= wr_data[1:0];
          REG_TRANS:    trans_shadow_reg    <= wr_data[TRANSPARENCY_PRECISION-1:0];
          REG_OFFSET_X: offset_x_shadow_reg <= wr_data[PRECISION:0];
          REG_OFFSET_Y: offset_y_shadow_reg <= wr_data[PRECISION:0];
          REG_CLIP_L:   clip_l_shadow_reg   <= wr_data[PRECISION-1:0];
          REG_CLIP_R:   clip_r_shadow_reg   <= wr_data[PRECISION-1:0];
          REG_CLIP_T:   clip_t_shadow_reg   <= wr_data[PRECISION-1:0];
          REG_CLIP_B:   clip_b_shadow_reg   <= wr_data[PRECISION-1:0];
          default: ;
        endcase
      end
      if (commit) begin
        mode         <= mode_shadow_reg;
        scale        <= scale_shadow_reg;
        offset_x     <= offset_x_shadow_reg;
        offset_y     <= offset_y_shadow_reg;
        transparency <= trans_shadow_reg;
        clip_left    <= clip_l_shadow_reg;
        clip_right   <= clip_r_shadow_reg;
        clip_top     <= clip_t_shadow_reg;
        clip_bottom  <= clip_b_shadow_reg;
      end
    end
  end

endmodule

// File: rtl/layer_ctrl_bank.sv
// Command-stream parser plus per-layer shadow/active register bank.
// Optional error counter output enabled by macro LAYER_CTRL_ERRCNT_EN.
module layer_ctrl_bank
  import layer_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS             = 2,
  parameter int PRECISION              = 11,
  parameter int TRANSPARENCY_PRECISION = 3
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [7:0]                                   cmd_byte,
  input  logic                                         cmd_valid,
  input  logic                                         cmd_abort,
  input  logic                                         frame_start,
  output logic [2*NUM_LAYERS-1:0]                      ctrl_overlay_mode,
  output logic [2*NUM_LAYERS-1:0]                      ctrl_fg_scale,
  output logic [(PRECISION+1)*NUM_LAYERS-1:0]          ctrl_fg_offset_x,
  output logic [(PRECISION+1)*NUM_LAYERS-1:0]          ctrl_fg_offset_y,
  output logic [TRANSPARENCY_PRECISION*NUM_LAYERS-1:0] ctrl_fg_transparency,
  output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_left,
  output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_right,
  output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_top,
  output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_bottom,
  output logic                                         ctrl_fg_freeze,
  output logic                                         commit_pending,
`ifdef LAYER_CTRL_ERRCNT_EN
  output logic [7:0]                                   err_count,
`endif
  output logic                                         cmd_error
);

  parse_state_t state_reg, state_next;
  logic [1:0]   layer_reg, layer_next;
  logic [3:0]   reg_id_reg, reg_id_next;
  logic [7:0]   hi_reg, hi_next;
  logic         cmd_error_reg, cmd_error_next;
  logic         commit_now_reg, commit_now_next;
  logic         pending_reg, freeze_shadow_reg, freeze_active_reg;
  logic         wr_en, commit;

  logic [1:0] hdr_layer;
  logic [3:0] hdr_reg;
  logic [1:0] hdr_rsvd;
  logic       hdr_global, hdr_bad;

  assign hdr_layer  = cmd_byte[HDR_LAYER_MSB:HDR_LAYER_LSB];
  assign hdr_reg    = cmd_byte[HDR_REG_MSB:HDR_REG_LSB];
  assign hdr_rsvd   = cmd_byte[HDR_RSVD_MSB:HDR_RSVD_LSB];
  // Freeze and commit-now are bank-wide, so their layer field is don't-care.
  assign hdr_global = (hdr_reg == REG_FREEZE) || (hdr_reg == REG_COMMIT);
  assign hdr_bad    = (!hdr_global && (int'(hdr_layer) >= NUM_LAYERS)) ||
                      (hdr_reg > REG_COMMIT) || (hdr_rsvd != 2'b00);

  always_comb begin
    state_next      = state_reg;
    layer_next      = layer_reg;
    reg_id_next     = reg_id_reg;
    hi_next         = hi_reg;
    cmd_error_next  = 1'b0;
    commit_now_next = 1'b0;
    wr_en           = 1'b0;
    if (cmd_abort) begin
      state_next = ST_IDLE;
    end else if (cmd_valid) begin
      case (state_reg)
        ST_IDLE: begin
          if (hdr_bad) begin
            cmd_error_next = 1'b1;
          end else if (hdr_reg == REG_COMMIT) begin
            commit_now_next = 1'b1;
          end else begin
            layer_next  = hdr_layer;
            reg_id_next = hdr_reg;
            hi_next     = 8'h00;
            state_next  = is_two_byte(hdr_reg) ? ST_PAY_HI : ST_PAY_LO;
          end
        end
        ST_PAY_HI: begin
          hi_next    = cmd_byte;
          state_next = ST_PAY_LO;
        end
        ST_PAY_LO: begin
          wr_en      = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign commit = frame_start || commit_now_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      layer_reg         <= '0;
      reg_id_reg        <= '0;
      hi_reg            <= '0;
      cmd_error_reg     <= 1'b0;
      commit_now_reg    <= 1'b0;
      pending_reg       <= 1'b0;
      freeze_shadow_reg <= 1'b0;
      freeze_active_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      layer_reg      <= layer_next;
      reg_id_reg     <= reg_id_next;
      hi_reg         <= hi_next;
      cmd_error_reg  <= cmd_error_next;
      commit_now_reg <= commit_now_next;
      if (wr_en) pending_reg <= 1'b1;
      else if (commit) pending_reg <= 1'b0;
      if (wr_en && (reg_id_reg == REG_FREEZE)) freeze_shadow_reg <= cmd_byte[0];
      if (commit) freeze_active_reg <= freeze_shadow_reg;
    end
  end

  assign cmd_error      = cmd_error_reg;
  assign commit_pending = pending_reg;
  assign ctrl_fg_freeze = freeze_active_reg;

  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
      logic slice_wr_en;
      assign slice_wr_en = wr_en && (layer_reg == 2'(gi));
      layer_ctrl_slice #(
        .PRECISION              (PRECISION),
        .TRANSPARENCY_PRECISION (TRANSPARENCY_PRECISION)
      ) u_slice (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (slice_wr_en),
        .wr_reg       (reg_id_reg),
        .wr_data      ({hi_reg, cmd_byte}),
        .commit       (commit),
        .mode         (ctrl_overlay_mode[2*gi +: 2]),
        .scale        (ctrl_fg_scale[2*gi +: 2]),
        .offset_x     (ctrl_fg_offset_x[(PRECISION+1)*gi +: PRECISION+1]),
        .offset_y     (ctrl_fg_offset_y[(PRECISION+1)*gi +: PRECISION+1]),
        .transparency (ctrl_fg_transparency[TRANSPARENCY_PRECISION*gi +: TRANSPARENCY_PRECISION]),
        .clip_left    (ctrl_fg_clip_left[PRECISION*gi +: PRECISION]),
        .clip_right   (ctrl_fg_clip_right[PRECISION*gi +: PRECISION]),
        .clip_top     (ctrl_fg_clip_top[PRECISION*gi +: PRECISION]),
        .clip_bottom  (ctrl_fg_clip_bottom[PRECISION*gi +: PRECISION])
      );
    end
  endgenerate

`ifdef LAYER_CTRL_ERRCNT_EN
  logic [7:0] err_count_reg;
  always_ff @(posedge clk) begin
    if (rst) err_count_reg <= 8'h00;
    else if (cmd_error_reg && (err_count_reg != 8'hFF)) err_count_reg <= err_count_reg + 8'h01;
  end
  assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_layer_ctrl_bank.sv
// Directed bench for layer_ctrl_bank: a table of single-register writes
// committed by frame_start, then hand-written multi-cycle corner cases.
module tb_layer_ctrl_bank;
  localparam int NL = 2;
  localparam int P  = 11;
  localparam int TP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] cmd_byte = 8'h00;
  logic cmd_valid = 1'b0, cmd_abort = 1'b0, frame_start = 1'b0;
  logic [2*NL-1:0] ctrl_overlay_mode, ctrl_fg_scale;
  logic [(P+1)*NL-1:0] ctrl_fg_offset_x, ctrl_fg_offset_y;
  logic [TP*NL-1:0] ctrl_fg_transparency;
  logic [P*NL-1:0] ctrl_fg_clip_left, ctrl_fg_clip_right, ctrl_fg_clip_top, ctrl_fg_clip_bottom;
  logic ctrl_fg_freeze, commit_pending, cmd_error;
`ifdef LAYER_CTRL_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int model [9][NL];

  layer_ctrl_bank #(.NUM_LAYERS(NL), .PRECISION(P), .TRANSPARENCY_PRECISION(TP)) dut (
    .clk(clk), .rst(rst), .cmd_byte(cmd_byte), .cmd_valid(cmd_valid),
    .cmd_abort(cmd_abort), .frame_start(frame_start),
    .ctrl_overlay_mode(ctrl_overlay_mode), .ctrl_fg_scale(ctrl_fg_scale),
    .ctrl_fg_offset_x(ctrl_fg_offset_x), .ctrl_fg_offset_y(ctrl_fg_offset_y),
    .ctrl_fg_transparency(ctrl_fg_transparency),
    .ctrl_fg_clip_left(ctrl_fg_clip_left), .ctrl_fg_clip_right(ctrl_fg_clip_right),
    .ctrl_fg_clip_top(ctrl_fg_clip_top), .ctrl_fg_clip_bottom(ctrl_fg_clip_bottom),
    .ctrl_fg_freeze(ctrl_fg_freeze), .commit_pending(commit_pending),
`ifdef LAYER_CTRL_ERRCNT_EN
    .err_count(err_count),
`endif
    .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    int         fld;
    int         lyr;
    int         exp;
  } vec_t;
  vec_t vecs [10];

  // fld: 0 mode, 1 scale, 2 transparency, 3 offset_x, 4 offset_y, 5..8 clip l/r/t/b
  function automatic int field(input int f, input int l);
    case (f)
      0: return int'(ctrl_overlay_mode[2*l +: 2]);
      1: return int'(ctrl_fg_scale[2*l +: 2]);
      2: return int'(ctrl_fg_transparency[TP*l +: TP]);
      3: return int'(ctrl_fg_offset_x[(P+1)*l +: P+1]);
      4: return int'(ctrl_fg_offset_y[(P+1)*l +: P+1]);
      5: return int'(ctrl_fg_clip_left[P*l +: P]);
      6: return int'(ctrl_fg_clip_right[P*l +: P]);
      7: return int'(ctrl_fg_clip_top[P*l +: P]);
      default: return int'(ctrl_fg_clip_bottom[P*l +: P]);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // All drive tasks start and end on a falling edge.
  task automatic send(input logic [7:0] b);
    cmd_byte = b; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_byte = 8'h00;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int f = 0; f < 9; f++) for (int l = 0; l < NL; l++) model[f][l] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h00, 8'h02, 8'h00, 2, 0, 0, 2};
    vecs[1] = '{8'h44, 8'h03, 8'h00, 2, 1, 1, 3};
    vecs[2] = '{8'h08, 8'hFD, 8'h00, 2, 2, 0, 5};
    vecs[3] = '{8'h4C, 8'h01, 8'h2C, 3, 3, 1, 300};
    vecs[4] = '{8'h10, 8'hFF, 8'hFE, 3, 4, 0, 12'hFFE};
    vecs[5] = '{8'h14, 8'h07, 8'hFF, 3, 5, 0, 11'h7FF};
    vecs[6] = '{8'h58, 8'h12, 8'h34, 3, 6, 1, 11'h234};
    vecs[7] = '{8'h1C, 8'h00, 8'h05, 3, 7, 0, 5};
    vecs[8] = '{8'h60, 8'h00, 8'h0A, 3, 8, 1, 10};
    vecs[9] = '{8'h00, 8'h01, 8'h00, 2, 0, 0, 1};

    @(negedge clk);
    do_reset();
    for (int f = 0; f < 9; f++)
      for (int l = 0; l < NL; l++) check($sformatf("reset f%0d l%0d", f, l), field(f, l), 0);
    check("reset freeze", int'(ctrl_fg_freeze), 0);
    check("reset pending", int'(commit_pending), 0);
    check("reset cmd_error", int'(cmd_error), 0);

    // Table: write, confirm shadow-only, commit on frame_start, confirm active.
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].b0);
      send(vecs[i].b1);
      if (vecs[i].n == 3) send(vecs[i].b2);
      check($sformatf("vec%0d pending", i), int'(commit_pending), 1);
      check($sformatf("vec%0d held", i), field(vecs[i].fld, vecs[i].lyr), model[vecs[i].fld][vecs[i].lyr]);
      pulse_fs();
      model[vecs[i].fld][vecs[i].lyr] = vecs[i].exp;
      check($sformatf("vec%0d active", i), field(vecs[i].fld, vecs[i].lyr), vecs[i].exp);
      check($sformatf("vec%0d cleared", i), int'(commit_pending), 0);
    end
    for (int f = 0; f < 9; f++)
      for (int l = 0; l < NL; l++) check($sformatf("table f%0d l%0d", f, l), field(f, l), model[f][l]);

    // Invalid layer header, then a fresh header + payload.
    do_reset();
    send(8'h80);
    check("bad hdr error", int'(cmd_error), 1);
    check("bad hdr mode", int'(ctrl_overlay_mode), 0);
    check("bad hdr pending", int'(commit_pending), 0);
    send(8'h00);
    check("bad hdr one pulse", int'(cmd_error), 0);
    send(8'h02);
    check("after bad pending", int'(commit_pending), 1);
    pulse_fs();
    check("after bad mode l0", field(0, 0), 2);

    // Abort mid-payload; following byte must be a header (commit-now).
    do_reset();
    send(8'h14);
    send(8'h0F);
    cmd_abort = 1'b1; @(negedge clk); cmd_abort = 1'b0;
    send(8'h28);
    @(negedge clk);
    pulse_fs();
    check("abort clip_left", field(5, 0), 0);
    check("abort pending", int'(commit_pending), 0);

    // Final payload byte coincident with frame_start.
    do_reset();
    send(8'h00);
    cmd_byte = 8'h01; cmd_valid = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; frame_start = 1'b0; cmd_byte = 8'h00;
    check("coincide mode", field(0, 0), 0);
    check("coincide pending", int'(commit_pending), 1);
    pulse_fs();
    check("coincide next mode", field(0, 0), 1);

    // Freeze via commit-now: active two cycles after the commit header.
    do_reset();
    send(8'h24);
    send(8'h01);
    check("freeze pending", int'(commit_pending), 1);
    send(8'h28);
    check("freeze cycle1", int'(ctrl_fg_freeze), 0);
    @(negedge clk);
    check("freeze cycle2", int'(ctrl_fg_freeze), 1);
    check("freeze cleared", int'(commit_pending), 0);

    // Reset mid-command drops the partial write.
    do_reset();
    send(8'h14);
    send(8'h07);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    send(8'hFF);
    check("rst mid error", int'(cmd_error), 1);
    pulse_fs();
    check("rst mid clip_left", field(5, 0), 0);

`ifdef LAYER_CTRL_ERRCNT_EN
    do_reset();
    for (int i = 0; i < 300; i++) send(8'h80);
    @(negedge clk);
    check("err_count sat", int'(err_count), 255);
    do_reset();
    check("err_count rst", int'(err_count), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
